machine_seq_ctrl: RTL and testbench

Run controller for the 3-bit serial move FSM (the `x`/`F`/`S` machine). It accepts an LEN-bit pattern through a start/ready handshake. It resets the FSM for one cycle, then streams the pattern into `x` LSB-first, one bit per cycle. It watches the FSM's Moore output `F` and reports the first hit index, the hit count and the final FSM state with a one-cycle `done` pulse.

---
 rtl/machine_seq_ctrl.sv | 90 +++++++++
 tb/tb_machine_seq_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/machine_seq_ctrl.sv
// machine_seq_ctrl: streams a latched pattern LSB-first into the serial move FSM and reports F hits and the final state
module machine_seq_ctrl #(
  parameter int LEN = 8,
  localparam int CW = $clog2(LEN + 1)
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           start,
  input  logic           abort,
  input  logic [LEN-1:0] pattern,
  output logic           ready,
  output logic           busy,
  output logic           m_x,
  output logic           m_rst_n,
  input  logic           m_F,
  input  logic [2:0]     m_S,
  output logic           done,
  output logic           hit,
  output logic [CW-1:0]  hit_idx,
  output logic [CW-1:0]  hit_cnt,
  output logic [2:0]     final_s
);
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t         r_state, w_next;
  logic [LEN-1:0] r_shreg;
  logic [CW-1:0]  r_k;
  logic           r_hit;
  logic [CW-1:0]  r_hit_idx, r_hit_cnt;
  logic [2:0]     r_final_s;
  logic           w_acc, w_kill, w_samp, w_last;
  assign ready   = r_state == S_IDLE;
  assign busy    = r_state == S_CLEAR || r_state == S_RUN || r_state == S_DRAIN;
  assign done    = r_state == S_DONE;
  assign m_x     = r_state == S_RUN && r_shreg[0];
  assign m_rst_n = RESET && r_state != S_CLEAR;
  assign hit     = r_hit;
  assign hit_idx = r_hit_idx;
  assign hit_cnt = r_hit_cnt;
  assign final_s = r_final_s;
  assign w_acc   = ready && start && !abort;
  assign w_kill  = busy && abort;
  assign w_last  = r_k == CW'(LEN - 1);
  // F lags x by one cycle, so the edge closing RUN cycle k (or DRAIN, where k=LEN) reports bit k-1
  assign w_samp  = (r_state == S_RUN && r_k != '0) || r_state == S_DRAIN;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_acc ? S_CLEAR : S_IDLE;
      S_CLEAR: w_next = abort ? S_IDLE : S_RUN;
      S_RUN:   w_next = abort ? S_IDLE : (w_last ? S_DRAIN : S_RUN);
      S_DRAIN: w_next = abort ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      r_shreg   <= '0;
      r_k       <= '0;
      r_hit     <= 1'b0;
      r_hit_idx <= '0;
      r_hit_cnt <= '0;
      r_final_s <= 3'b000;
    end else if (w_acc) begin
      r_shreg   <= pattern;
      r_k       <= '0;
      r_hit     <= 1'b0;
      r_hit_idx <= '0;
      r_hit_cnt <= '0;
      r_final_s <= 3'b000;
    end else if (w_kill) begin
      r_hit     <= 1'b0;
      r_hit_idx <= '0;
      r_hit_cnt <= '0;
      r_final_s <= 3'b000;
    end else begin
      if (r_state == S_RUN) begin
        r_shreg <= r_shreg >> 1;
        r_k     <= r_k + CW'(1);
      end
      if (w_samp && m_F) begin
        r_hit     <= 1'b1;
        r_hit_cnt <= r_hit_cnt + CW'(1);
        if (!r_hit) r_hit_idx <= r_k - CW'(1);
      end
      if (r_state == S_DRAIN) r_final_s <= m_S;
    end
endmodule

// File: tb/tb_machine_seq_ctrl.sv
// tb_machine_seq_ctrl: drives machine_seq_ctrl against a model of the serial move FSM and checks each run
module tb_machine_seq_ctrl;
  localparam int LEN = 8;
  localparam int CW = 4;
  logic           CLK = 1'b0, RESET = 1'b0, start = 1'b0, abort = 1'b0;
  logic [LEN-1:0] pattern = '0;
  logic           ready, busy, m_x, m_rst_n, m_F, done, hit;
  logic [2:0]     m_S, final_s, fsm_s;
  logic [CW-1:0]  hit_idx, hit_cnt;
  int             n_chk = 0, n_pass = 0;
  logic [7:0]     dp [4] = '{8'h00, 8'h01, 8'h55, 8'h40};
  int             di [4] = '{0, 1, 1, 7};
  int             dc [4] = '{0, 1, 2, 1};
  logic [2:0]     df [4] = '{3'b000, 3'b000, 3'b001, 3'b110};

  always #5 CLK = ~CLK;

  machine_seq_ctrl #(.LEN(LEN)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .abort(abort), .pattern(pattern),
    .ready(ready), .busy(busy), .m_x(m_x), .m_rst_n(m_rst_n), .m_F(m_F), .m_S(m_S),
    .done(done), .hit(hit), .hit_idx(hit_idx), .hit_cnt(hit_cnt), .final_s(final_s)
  );

  // Serial move FSM stand-in: resets to 111, any 1 jumps to 011 (110 falls to 000), F only in 110
  function automatic logic [2:0] fsm_next(input logic [2:0] s, input logic x);
    if (x) return (s == 3'b110) ? 3'b000 : 3'b011;
    case (s)
      3'b000:  return 3'b001;
      3'b001:  return 3'b010;
      3'b010:  return 3'b100;
      3'b100:  return 3'b101;
      3'b011:  return 3'b110;
      3'b111:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  always @(posedge CLK or negedge m_rst_n)
    if (!m_rst_n) fsm_s <= 3'b111;
    else fsm_s <= fsm_next(fsm_s, m_x);
  assign m_S = fsm_s;
  assign m_F = fsm_s == 3'b110;

  task automatic ref_run(input logic [LEN-1:0] p, output logic h, output int idx, output int cnt,
                         output logic [2:0] fs);
    logic [2:0] s;
    s = 3'b111; h = 1'b0; idx = 0; cnt = 0;
    for (int i = 0; i < LEN; i++) begin
      s = fsm_next(s, p[i]);
      if (s == 3'b110) begin
        if (!h) idx = i;
        h = 1'b1;
        cnt++;
      end
    end
    fs = s;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !ready; i++) tick();
    chk("ready_wait", 32'(ready), 1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      cyc = i;
      if (done) break;
    end
  endtask

  task automatic do_run(input logic [LEN-1:0] pat, input logic pulse);
    logic [LEN-1:0] xs;
    logic           eh;
    logic [2:0]     efs;
    int             ei, ec, cyc, lows;
    ref_run(pat, eh, ei, ec, efs);
    wait_ready();
    start = 1'b1;
    pattern = pat;
    tick();
    start = 1'b0;
    chk("clear_rst_n", 32'(m_rst_n), 0);
    chk("clear_busy", 32'(busy), 1);
    xs = '0; lows = 1; cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      cyc = i;
      if (i <= LEN) xs[i-1] = m_x;
      if (!m_rst_n) lows++;
      if (done) break;
      if (pulse) begin
        start = 1'($urandom_range(1));
        pattern = LEN'($urandom);
      end
    end
    start = 1'b0;
    chk("latency", cyc, LEN + 2);
    chk("rst_low_cycles", lows, 1);
    chk("x_stream", 32'(xs), 32'(pat));
    chk("hit", 32'(hit), 32'(eh));
    chk("hit_idx", 32'(hit_idx), ei);
    chk("hit_cnt", 32'(hit_cnt), ec);
    chk("final_s", 32'(final_s), 32'(efs));
    tick();
    chk("post_ready", 32'(ready), 1);
    chk("post_done", 32'(done), 0);
  endtask

  initial begin
    int  cyc;
    logic seen;
    #12;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_m_x", 32'(m_x), 0);
    chk("rst_m_rst_n", 32'(m_rst_n), 0);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_idx", 32'(hit_idx), 0);
    chk("rst_cnt", 32'(hit_cnt), 0);
    chk("rst_final", 32'(final_s), 0);
    @(negedge CLK);
    RESET = 1'b1;
    tick();
    start = 1'b1; abort = 1'b1; pattern = 8'h01;
    tick();
    chk("idle_abort_ready", 32'(ready), 1);
    chk("idle_abort_busy", 32'(busy), 0);
    start = 1'b0; abort = 1'b0;

    for (int i = 0; i < 4; i++) begin
      do_run(dp[i], 1'b0);
      chk($sformatf("dir%0d_hit", i), 32'(hit), 32'(dp[i] != 8'h00));
      chk($sformatf("dir%0d_idx", i), 32'(hit_idx), di[i]);
      chk($sformatf("dir%0d_cnt", i), 32'(hit_cnt), dc[i]);
      chk($sformatf("dir%0d_fs", i), 32'(final_s), 32'(df[i]));
    end

    do_run(8'h01, 1'b1);
    chk("pulse_idx", 32'(hit_idx), 1);
    chk("pulse_cnt", 32'(hit_cnt), 1);

    wait_ready();
    start = 1'b1; pattern = 8'h55;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("abort_pre_hit", 32'(hit), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ready", 32'(ready), 1);
    chk("abort_hit", 32'(hit), 0);
    chk("abort_cnt", 32'(hit_cnt), 0);
    chk("abort_idx", 32'(hit_idx), 0);
    chk("abort_fs", 32'(final_s), 0);
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen |= done;
    end
    chk("abort_no_done", 32'(seen), 0);
    do_run(8'h01, 1'b0);
    chk("after_abort_idx", 32'(hit_idx), 1);
    chk("after_abort_cnt", 32'(hit_cnt), 1);

    wait_ready();
    start = 1'b1; pattern = 8'h01;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("rstmid_pre_hit", 32'(hit), 1);
    RESET = 1'b0;
    #1;
    chk("rstmid_ready", 32'(ready), 1);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_m_rst_n", 32'(m_rst_n), 0);
    chk("rstmid_hit", 32'(hit), 0);
    chk("rstmid_cnt", 32'(hit_cnt), 0);
    chk("rstmid_m_x", 32'(m_x), 0);
    @(negedge CLK);
    RESET = 1'b1;

    wait_ready();
    start = 1'b1; pattern = 8'h55;
    tick();
    wait_done(cyc);
    chk("b2b_lat1", cyc, LEN + 2);
    tick();
    chk("b2b_idle", 32'(ready), 1);
    tick();
    chk("b2b_accept", 32'(busy), 1);
    chk("b2b_clear", 32'(m_rst_n), 0);
    start = 1'b0;
    wait_done(cyc);
    chk("b2b_lat2", cyc, LEN + 2);
    chk("b2b_cnt", 32'(hit_cnt), 2);
    chk("b2b_fs", 32'(final_s), 32'(3'b001));

    for (int r = 0; r < 10; r++) do_run(LEN'($urandom), 1'($urandom_range(1)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
